// File: rtl/parity_pkg.sv
// Parity constants shared by the parity generator and checker blocks.
package parity_pkg;

    localparam logic PAR_ODD  = 1'b1;
    localparam logic PAR_EVEN = 1'b0;

endpackage : parity_pkg

// File: rtl/parity_reduce.sv
// Combinational XOR reduction of one data word.
module parity_reduce #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] data_i,
    output logic         par_c
);

    assign par_c = ^data_i;

endmodule : parity_reduce

// File: rtl/parity_check_stream.sv
// Pipelined frame parity checker with valid/ready on both sides, a sticky
// error flag and a saturating errored-frame counter.
module parity_check_stream
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_par,
    input  logic              odd_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_err,
    input  logic              clr_err,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_last_q,  out_last_d;
    logic              out_err_q,   out_err_d;
    logic              sticky_q,    sticky_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              acc_q,       acc_d;
    logic              mid_frame_q, mid_frame_d;
    logic              mode_q,      mode_d;

    logic data_par_c;
    logic accept_c;
    logic acc_in_c;
    logic mode_c;
    logic frame_err_c;
    logic err_event_c;

    parity_reduce #(.W(DATA_W)) u_reduce (
        .data_i (in_data),
        .par_c  (data_par_c)
    );

    assign in_ready = ~out_valid_q | out_ready;
    assign accept_c = in_valid & in_ready;

    // First beat of a frame sees a zero accumulator and the live mode input.
    assign acc_in_c    = (mid_frame_q ? acc_q : 1'b0) ^ data_par_c;
    assign mode_c      = mid_frame_q ? mode_q : odd_mode;
    assign frame_err_c = (mode_c == PAR_ODD) ? ~(acc_in_c ^ in_par) : (acc_in_c ^ in_par);
    assign err_event_c = accept_c & in_last & frame_err_c;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        acc_d       = acc_q;
        mid_frame_d = mid_frame_q;
        mode_d      = mode_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;

        if (accept_c) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_last_d  = in_last;
            out_err_d   = in_last & frame_err_c;
            if (!mid_frame_q) begin
                mode_d = odd_mode;
            end
            if (in_last) begin
                acc_d       = 1'b0;
                mid_frame_d = 1'b0;
            end else begin
                acc_d       = acc_in_c;
                mid_frame_d = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clear takes effect first, so a same-cycle error counts as one.
        if (clr_err) begin
            sticky_d = err_event_c;
            cnt_d    = err_event_c ? CNT_W'(1) : '0;
        end else if (err_event_c) begin
            sticky_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
            acc_q       <= 1'b0;
            mid_frame_q <= 1'b0;
            mode_q      <= PAR_ODD;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
            acc_q       <= acc_d;
            mid_frame_q <= mid_frame_d;
            mode_q      <= mode_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign out_err    = out_err_q;
    assign err_sticky = sticky_q;
    assign err_cnt    = cnt_q;

endmodule : parity_check_stream

// File: tb/tb_parity_check_stream.sv
// Randomized self-checking bench for parity_check_stream against a frame-level model.
module tb_parity_check_stream;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 2;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, in_last, in_par, odd_mode;
    logic [DATA_W-1:0] in_data;
    logic              out_valid, out_ready, out_last, out_err;
    logic [DATA_W-1:0] out_data;
    logic              clr_err, err_sticky;
    logic [CNT_W-1:0]  err_cnt;

    parity_check_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_par     (in_par),
        .odd_mode   (odd_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_err    (out_err),
        .clr_err    (clr_err),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pending output beats, frame-level ones count, error stats.
    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              err;
    } beat_t;

    beat_t pend_q[$];
    int    frame_ones = 0;
    bit    in_frame   = 0;
    bit    frame_odd  = 1;
    int    m_cnt      = 0;
    bit    m_sticky   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(pend_q.size() != 0));
        if (pend_q.size() != 0) begin
            check("out_data", 32'(out_data), 32'(pend_q[0].data));
            check("out_last", 32'(out_last), 32'(pend_q[0].last));
            check("out_err",  32'(out_err),  32'(pend_q[0].err));
        end
        check("err_cnt",    32'(err_cnt),    32'(m_cnt));
        check("err_sticky", 32'(err_sticky), 32'(m_sticky));
    endtask

    task automatic model_reset();
        pend_q.delete();
        frame_ones = 0;
        in_frame   = 0;
        m_cnt      = 0;
        m_sticky   = 0;
    endtask

    // Drive one cycle at the negedge, predict the posedge, check at the next negedge.
    task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit l, input bit p,
                        input bit odd, input bit ordy, input bit clr);
        bit    rdy, acc, err, ev;
        int    tot;
        beat_t b;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        in_par    = p;
        odd_mode  = odd;
        out_ready = ordy;
        clr_err   = clr;
        #1;
        rdy = (pend_q.size() == 0) || ordy;
        check("in_ready", 32'(in_ready), 32'(rdy));
        acc = v && rdy;
        ev  = 0;
        if (pend_q.size() != 0 && ordy) void'(pend_q.pop_front());
        if (acc) begin
            if (!in_frame) frame_odd = odd;
            frame_ones += $countones(d);
            err = 0;
            if (l) begin
                tot = frame_ones + int'(p);
                err = frame_odd ? (tot % 2 == 0) : (tot % 2 == 1);
                ev  = err;
                frame_ones = 0;
                in_frame   = 0;
            end else begin
                in_frame = 1;
            end
            b.data = d; b.last = l; b.err = err;
            pend_q.push_back(b);
        end
        if (clr) begin
            m_cnt    = ev ? 1 : 0;
            m_sticky = ev;
        end else if (ev) begin
            m_sticky = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        step(0, '0, 0, 0, 1, 1, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_data = '0; in_last = 0; in_par = 0;
        odd_mode = 1; out_ready = 1; clr_err = 0;
        repeat (3) @(negedge clk);
        check_outputs();
        check("rst_out_data", 32'(out_data), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-beat odd frames: good parity then bad parity.
        step(1, 8'h06, 1, 1, 1, 1, 0);
        step(1, 8'h06, 1, 0, 1, 1, 0);
        idle();
        // Even three-beat frame with odd_mode toggling mid-frame.
        step(1, 8'h01, 0, 0, 0, 1, 0);
        step(1, 8'h03, 0, 0, 1, 1, 0);
        step(1, 8'h00, 1, 1, 1, 1, 0);
        idle();
        // Backpressure: hold a beat, then simultaneous transfer and accept.
        step(1, 8'hA5, 0, 0, 1, 0, 0);
        repeat (3) step(1, 8'h3C, 1, 0, 1, 0, 0);
        step(1, 8'h3C, 1, 0, 1, 1, 0);
        idle();
        // Saturation, clear with concurrent error, clear alone.
        repeat (5) step(1, 8'h00, 1, 0, 1, 1, 0);
        step(1, 8'h00, 1, 0, 1, 1, 1);
        step(0, '0, 0, 0, 1, 1, 1);
        idle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, DATA_W'($urandom),
                 $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
        end
        repeat (2) idle();

        // Reset after the second beat of a frame discards it.
        step(1, 8'h01, 0, 0, 0, 1, 0);
        step(1, 8'h02, 0, 0, 0, 0, 0);
        step(1, 8'h00, 1, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        // New frame must start from a clean accumulator with its own mode.
        step(1, 8'h07, 0, 0, 1, 1, 0);
        step(1, 8'h00, 1, 0, 0, 1, 0);
        step(1, 8'h07, 0, 0, 0, 1, 0);
        step(1, 8'h00, 1, 1, 1, 1, 0);
        repeat (2) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_parity_check_stream
